in_port_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the memory-mapped I/O port block and drives its 4-bit `in_port` input. Each raw external line is synchronised into `clk`, debounced with a per-bit stability counter, and presented as a clean level. Rising edges of the clean level are also captured as sticky per-bit event flags, so software polling the input address cannot miss short button presses.

---
 rtl/in_port_conditioner.sv | 98 +++++++++
 tb/tb_in_port_conditioner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_port_conditioner.sv
// Input conditioner feeding the I/O port block's in_port: per-line synchroniser,
// stability-counter debounce, and sticky rising-edge event flags.

module in_port_conditioner_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_clear,
  output logic o_clean,
  output logic o_rise
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   w_sync;
  logic                   w_mismatch;
  logic                   w_accept;
  logic                   w_set;

  // Plain flop chain: no logic between stages so metastability can settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_sync ^ r_clean;
  assign w_accept   = w_mismatch && (r_cnt == LAST);
  assign w_set      = w_accept && w_sync;

  // Counter only advances on consecutive mismatches; any agreement discards it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else if (!w_mismatch || w_accept) begin
      r_cnt <= '0;
      if (w_accept) r_clean <= w_sync;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Set has priority over clear so a rise landing on a clear is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_rise <= 1'b0;
    else if (w_set)   r_rise <= 1'b1;
    else if (i_clear) r_rise <= 1'b0;
  end

  assign o_clean = r_clean;
  assign o_rise  = r_rise;
endmodule

module in_port_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clear_events,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_event,
  output logic             event_pending
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [WIDTH-1:0] w_clean;
  logic [WIDTH-1:0] w_rise;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    in_port_conditioner_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (raw_in[g]),
      .i_clear(clear_events[g]),
      .o_clean(w_clean[g]),
      .o_rise (w_rise[g])
    );
  end

  assign clean_out     = w_clean;
  assign rise_event    = w_rise;
  assign event_pending = |w_rise;
endmodule

// File: tb/tb_in_port_conditioner.sv
// Bench for in_port_conditioner: directed scenarios plus random stimulus against
// a sample-history reference model.

module tb_in_port_conditioner;
  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 16;
  localparam int H = S + D;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] clear_events = '0;
  logic [W-1:0] clean_out;
  logic [W-1:0] rise_event;
  logic         event_pending;

  int n_vec = 0;
  int n_err = 0;

  // Model: history of raw samples (index 0 = this edge); a level is accepted once
  // the D samples that have cleared the synchroniser all disagree with clean.
  logic [W-1:0] hist [0:H-1];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_rise;

  in_port_conditioner #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_in       (raw_in),
    .clear_events (clear_events),
    .clean_out    (clean_out),
    .rise_event   (rise_event),
    .event_pending(event_pending)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < H; k++) hist[k] = '0;
    m_clean = '0;
    m_rise  = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] r, input logic [W-1:0] c);
    logic acc;
    for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = r;
    for (int b = 0; b < W; b++) begin
      acc = 1'b1;
      for (int k = S; k < H; k++) if (hist[k][b] == m_clean[b]) acc = 1'b0;
      if (acc && !m_clean[b]) m_rise[b] = 1'b1;
      else if (c[b])          m_rise[b] = 1'b0;
      if (acc) m_clean[b] = ~m_clean[b];
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input logic [W-1:0] r, input logic [W-1:0] c);
    raw_in       = r;
    clear_events = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
  endtask

  task automatic apply_reset(input logic [W-1:0] r);
    reset        = 1'b1;
    raw_in       = r;
    clear_events = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    raw_in = 4'hF;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (clean_out !== 4'h0 || rise_event !== 4'h0 || event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: clean=%h rise=%h pend=%b want 0/0/0", clean_out, rise_event, event_pending);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step(4'hF, 4'h0);
      n_vec++;
      if (clean_out !== ((e >= 18) ? 4'hF : 4'h0) || rise_event !== ((e >= 18) ? 4'hF : 4'h0)
          || event_pending !== (e >= 18)) begin
        n_err++;
        $display("FAIL reset_release e=%0d: clean=%h rise=%h pend=%b", e, clean_out, rise_event, event_pending);
      end
    end
    step(4'hF, 4'hF);
    n_vec++;
    if (rise_event !== 4'h0 || event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_clear_all: rise=%h pend=%b want 0/0", rise_event, event_pending);
    end
  endtask

  task automatic test_glitch();
    int rose_at;
    int fell_at;
    apply_reset(4'h0);
    for (int e = 1; e <= 60; e++) begin
      step((e <= 15) ? 4'h1 : 4'h0, 4'h0);
      n_vec++;
      if (clean_out[0] !== 1'b0 || rise_event[0] !== 1'b0 || clean_out !== m_clean) begin
        n_err++;
        $display("FAIL glitch15 e=%0d: clean=%h rise=%h want clean 0", e, clean_out, rise_event);
      end
    end
    rose_at = -1;
    fell_at = -1;
    for (int e = 1; e <= 60; e++) begin
      step((e <= 16) ? 4'h1 : 4'h0, 4'h0);
      if (clean_out[0] === 1'b1 && rose_at < 0) rose_at = e;
      if (clean_out[0] === 1'b0 && rose_at > 0 && fell_at < 0) fell_at = e;
    end
    n_vec++;
    if (rose_at != 18 || fell_at != 34) begin
      n_err++;
      $display("FAIL glitch16_edges: rose=%0d fell=%0d want 18/34", rose_at, fell_at);
    end
    n_vec++;
    if (rise_event !== 4'h1) begin
      n_err++;
      $display("FAIL glitch16_event: rise=%h want 1", rise_event);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic       prev;
    int         rises;
    int         rose_at;
    pat     = 5'b01101;
    prev    = 1'b0;
    rises   = 0;
    rose_at = -1;
    apply_reset(4'h0);
    for (int e = 1; e <= 45; e++) begin
      step((e <= 5) ? {2'b00, pat[e-1], 1'b0} : 4'h2, 4'h0);
      if (!prev && clean_out[1]) begin
        rises++;
        rose_at = e;
      end
      prev = clean_out[1];
    end
    n_vec++;
    if (rises != 1 || rose_at != 23) begin
      n_err++;
      $display("FAIL bounce: rises=%0d at=%0d want 1 at 23", rises, rose_at);
    end
    n_vec++;
    if (rise_event !== 4'h2) begin
      n_err++;
      $display("FAIL bounce_event: rise=%h want 2", rise_event);
    end
  endtask

  task automatic test_collision();
    apply_reset(4'h0);
    repeat (18) step(4'h4, 4'h0);
    repeat (18) step(4'h0, 4'h0);
    n_vec++;
    if (clean_out !== 4'h0 || rise_event !== 4'h4) begin
      n_err++;
      $display("FAIL coll_prep: clean=%h rise=%h want 0/4", clean_out, rise_event);
    end
    repeat (17) step(4'h4, 4'h0);
    step(4'h4, 4'h4);
    n_vec++;
    if (clean_out !== 4'h4 || rise_event !== 4'h4) begin
      n_err++;
      $display("FAIL coll_set_wins: clean=%h rise=%h want 4/4", clean_out, rise_event);
    end
    step(4'h4, 4'h4);
    n_vec++;
    if (rise_event !== 4'h0 || event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL coll_clear: rise=%h pend=%b want 0/0", rise_event, event_pending);
    end
  endtask

  task automatic test_independence();
    apply_reset(4'h0);
    repeat (17) step(4'h9, 4'h0);
    n_vec++;
    if (rise_event !== 4'h0 || clean_out !== 4'h0) begin
      n_err++;
      $display("FAIL indep_early: clean=%h rise=%h want 0/0", clean_out, rise_event);
    end
    step(4'h9, 4'h0);
    n_vec++;
    if (rise_event !== 4'h9 || clean_out !== 4'h9 || event_pending !== 1'b1) begin
      n_err++;
      $display("FAIL indep_rise: clean=%h rise=%h want 9/9", clean_out, rise_event);
    end
    repeat (17) step(4'h1, 4'h0);
    n_vec++;
    if (clean_out !== 4'h9) begin
      n_err++;
      $display("FAIL indep_fall_early: clean=%h want 9", clean_out);
    end
    step(4'h1, 4'h0);
    n_vec++;
    if (clean_out !== 4'h1 || rise_event !== 4'h9) begin
      n_err++;
      $display("FAIL indep_fall: clean=%h rise=%h want 1/9", clean_out, rise_event);
    end
  endtask

  task automatic test_midcount_reset();
    apply_reset(4'h0);
    repeat (12) step(4'h1, 4'h0);
    reset = 1'b1;
    model_clear();
    #1;
    n_vec++;
    if (clean_out !== 4'h0 || rise_event !== 4'h0) begin
      n_err++;
      $display("FAIL midreset_async: clean=%h rise=%h want 0/0", clean_out, rise_event);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step(4'h1, 4'h0);
      n_vec++;
      if (clean_out[0] !== (e >= 18)) begin
        n_err++;
        $display("FAIL midreset_accept e=%0d: clean0=%b want %b", e, clean_out[0], (e >= 18));
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r;
    logic [W-1:0] c;
    apply_reset(4'h0);
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(11) == 0) r[b] = ~r[b];
      for (int b = 0; b < W; b++) c[b] = ($urandom_range(7) == 0);
      step(r, c);
      n_vec++;
      if (clean_out !== m_clean || rise_event !== m_rise || event_pending !== (|m_rise)) begin
        n_err++;
        $display("FAIL random i=%0d: clean=%h rise=%h pend=%b want %h/%h/%b",
                 i, clean_out, rise_event, event_pending, m_clean, m_rise, |m_rise);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_collision();
    test_independence();
    test_midcount_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
